// File: rtl/mem_arbiter_if.sv
// Signal bundle between the memory arbiter, the RAM/UART bus and its requesters
// (icache, load/store buffer, reorder buffer).
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 1
);
    localparam int BLOCK_SIZE = 1 << BLOCK_WIDTH;

    logic [7:0]              mem_din;
    logic [7:0]              mem_dout;
    logic [ADDR_WIDTH-1:0]   mem_a;
    logic                    mem_wr;
    logic                    io_buffer_full;

    logic                    IC2MC_en;
    logic [ADDR_WIDTH-1:0]   IC2MC_addr;
    logic                    MC2IC_en;
    logic [32*BLOCK_SIZE-1:0] MC2IC_block;

    logic                    LSB2MC_en;
    logic                    LSB2MC_wr;
    logic [ADDR_WIDTH-1:0]   LSB2MC_addr;
    logic [1:0]              LSB2MC_len;
    logic [31:0]             LSB2MC_data;
    logic                    MC2LSB_en;
    logic [31:0]             MC2LSB_data;

    logic                    ROB2MC_pre_judge;

    // slave is the arbiter itself; master is everything around it
    modport slave (
        input  mem_din, io_buffer_full,
        input  IC2MC_en, IC2MC_addr,
        input  LSB2MC_en, LSB2MC_wr, LSB2MC_addr, LSB2MC_len, LSB2MC_data,
        input  ROB2MC_pre_judge,
        output mem_dout, mem_a, mem_wr,
        output MC2IC_en, MC2IC_block,
        output MC2LSB_en, MC2LSB_data
    );

    modport master (
        output mem_din, io_buffer_full,
        output IC2MC_en, IC2MC_addr,
        output LSB2MC_en, LSB2MC_wr, LSB2MC_addr, LSB2MC_len, LSB2MC_data,
        output ROB2MC_pre_judge,
        input  mem_dout, mem_a, mem_wr,
        input  MC2IC_en, MC2IC_block,
        input  MC2LSB_en, MC2LSB_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter: serves icache block fetches and LSB loads/stores
// over a single 8-bit RAM port, load/store requests taking priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 1
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    mem_arbiter_if.slave bus
);
    localparam int BLOCK_SIZE = 1 << BLOCK_WIDTH;
    localparam int NB         = 4 * BLOCK_SIZE;
    localparam int CNT_W      = $clog2(NB) + 1;
    localparam int BLK_W      = 8 * NB;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] IC_RD = 3'd1;
    localparam logic [2:0] LS_RD = 3'd2;
    localparam logic [2:0] LS_WR = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]            state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [CNT_W-1:0]      n_q,        n_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [31:0]           data_q,     data_d;
    logic [BLK_W-1:0]      buf_q,      buf_d;
    logic [ADDR_WIDTH-1:0] mem_a_q,    mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic                  mem_wr_q,   mem_wr_d;
    logic                  ic_en_q,    ic_en_d;
    logic                  ls_en_q,    ls_en_d;
    logic [BLK_W-1:0]      ic_block_q, ic_block_d;
    logic [31:0]           ls_data_q,  ls_data_d;

    logic [CNT_W-1:0]      cnt_nxt_s;
    logic                  flush_s;
    logic                  io_stall_s;

    function automatic logic [CNT_W-1:0] len_bytes(input logic [1:0] len);
        case (len)
            2'b00:   return CNT_W'(1);
            2'b01:   return CNT_W'(2);
            default: return CNT_W'(4);
        endcase
    endfunction

    function automatic logic [7:0] store_byte(input logic [31:0] d, input logic [CNT_W-1:0] k);
        case (k)
            CNT_W'(0): return d[7:0];
            CNT_W'(1): return d[15:8];
            CNT_W'(2): return d[23:16];
            default:   return d[31:24];
        endcase
    endfunction

    // A count of c means byte c-1 is on mem_din this cycle; c == 0 carries no data yet.
    function automatic logic [BLK_W-1:0] put_byte(input logic [BLK_W-1:0] b,
                                                  input logic [CNT_W-1:0] c,
                                                  input logic [7:0]       v);
        logic [BLK_W-1:0] r;
        r = b;
        for (int i = 0; i < NB; i++) begin
            if (c == CNT_W'(i + 1)) begin
                r[8*i +: 8] = v;
            end else begin
                r[8*i +: 8] = b[8*i +: 8];
            end
        end
        return r;
    endfunction

    assign cnt_nxt_s  = cnt_q + CNT_W'(1);
    assign flush_s    = !bus.ROB2MC_pre_judge;
    assign io_stall_s = (state_q == LS_WR) && (addr_q[17:16] == 2'b11) && bus.io_buffer_full;

    // Next-state logic for the access sequencer and its registered outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        addr_d     = addr_q;
        data_d     = data_q;
        buf_d      = buf_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        ic_en_d    = ic_en_q;
        ls_en_d    = ls_en_q;
        ic_block_d = ic_block_q;
        ls_data_d  = ls_data_q;

        // A misprediction kills reads even while paused; stores always run to completion.
        if (flush_s && ((state_q == IC_RD) || (state_q == LS_RD))) begin
            state_d  = IDLE;
            cnt_d    = '0;
            mem_a_d  = '0;
            mem_wr_d = 1'b0;
        end else if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    if (bus.LSB2MC_en && (bus.LSB2MC_wr || !flush_s)) begin
                        state_d  = bus.LSB2MC_wr ? LS_WR : LS_RD;
                        n_d      = len_bytes(bus.LSB2MC_len);
                        addr_d   = bus.LSB2MC_addr;
                        data_d   = bus.LSB2MC_data;
                        cnt_d    = '0;
                        buf_d    = '0;
                        mem_a_d  = bus.LSB2MC_addr;
                        mem_wr_d = bus.LSB2MC_wr;
                        if (bus.LSB2MC_wr) begin
                            mem_dout_d = bus.LSB2MC_data[7:0];
                        end else begin
                            mem_dout_d = mem_dout_q;
                        end
                    end else if (bus.IC2MC_en && !flush_s) begin
                        state_d  = IC_RD;
                        n_d      = CNT_W'(NB);
                        addr_d   = bus.IC2MC_addr;
                        cnt_d    = '0;
                        buf_d    = '0;
                        mem_a_d  = bus.IC2MC_addr;
                        mem_wr_d = 1'b0;
                    end else begin
                        mem_a_d  = '0;
                        mem_wr_d = 1'b0;
                    end
                end
                IC_RD, LS_RD: begin
                    buf_d = put_byte(buf_q, cnt_q, bus.mem_din);
                    if (cnt_q == n_q) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        mem_a_d = '0;
                        if (state_q == IC_RD) begin
                            ic_en_d    = 1'b1;
                            ic_block_d = buf_d;
                        end else begin
                            ls_en_d   = 1'b1;
                            ls_data_d = buf_d[31:0];
                        end
                    end else begin
                        cnt_d = cnt_nxt_s;
                        // Park the address after the last byte so no extra RAM/IO read is issued.
                        if (cnt_nxt_s < n_q) begin
                            mem_a_d = addr_q + ADDR_WIDTH'(cnt_nxt_s);
                        end else begin
                            mem_a_d = '0;
                        end
                    end
                end
                LS_WR: begin
                    if (!io_stall_s) begin
                        if (cnt_nxt_s == n_q) begin
                            state_d  = DONE;
                            cnt_d    = '0;
                            mem_a_d  = '0;
                            mem_wr_d = 1'b0;
                            ls_en_d  = 1'b1;
                        end else begin
                            cnt_d      = cnt_nxt_s;
                            mem_a_d    = addr_q + ADDR_WIDTH'(cnt_nxt_s);
                            mem_dout_d = store_byte(data_q, cnt_nxt_s);
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    ic_en_d = 1'b0;
                    ls_en_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    mem_a_d  = '0;
                    mem_wr_d = 1'b0;
                    ic_en_d  = 1'b0;
                    ls_en_d  = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            buf_q      <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'h00;
            mem_wr_q   <= 1'b0;
            ic_en_q    <= 1'b0;
            ls_en_q    <= 1'b0;
            ic_block_q <= '0;
            ls_data_q  <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            buf_q      <= buf_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            ic_en_q    <= ic_en_d;
            ls_en_q    <= ls_en_d;
            ic_block_q <= ic_block_d;
            ls_data_q  <= ls_data_d;
        end
    end

    // The write strobe is the only output that reacts within the cycle: pause and UART-full gate it.
    assign bus.mem_wr      = mem_wr_q && rdy_in && !io_stall_s;
    assign bus.mem_a       = mem_a_q;
    assign bus.mem_dout    = mem_dout_q;
    assign bus.MC2IC_en    = ic_en_q;
    assign bus.MC2IC_block = ic_block_q;
    assign bus.MC2LSB_en   = ls_en_q;
    assign bus.MC2LSB_data = ls_data_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: block fetch, collision, IO stall, flush, pause, wrap, reset.
module tb_mem_arbiter;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    int tests = 0;
    int fails = 0;

    mem_arbiter_if #(.ADDR_WIDTH(32), .BLOCK_WIDTH(1)) bus ();

    mem_arbiter #(.ADDR_WIDTH(32), .BLOCK_WIDTH(1)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // RAM model: preloaded bytes plus a write log; it stalls together with the core.
    logic [7:0] wr_mem [0:4095];
    bit         wr_vld [0:4095];

    function automatic logic [11:0] ram_idx(input logic [31:0] a);
        return a[11:0] ^ {a[17:16], 10'd0};
    endfunction

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 8'h11;
            32'h0000_0101: return 8'h12;
            32'h0000_0102: return 8'h13;
            32'h0000_0103: return 8'h14;
            32'h0000_0104: return 8'h15;
            32'h0000_0105: return 8'h16;
            32'h0000_0106: return 8'h17;
            32'h0000_0107: return 8'h18;
            32'h0000_0200: return 8'hA1;
            32'h0000_0201: return 8'hB2;
            32'h0000_0202: return 8'hC3;
            32'h0000_0203: return 8'hD4;
            32'h0000_0300: return 8'h5A;
            32'h0000_0301: return 8'h6B;
            32'h0000_0302: return 8'h7C;
            32'hFFFF_FFFE: return 8'h01;
            32'hFFFF_FFFF: return 8'h02;
            32'h0000_0000: return 8'h03;
            32'h0000_0001: return 8'h04;
            default:       return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        logic [11:0] i;
        i = ram_idx(a);
        return wr_vld[i] ? wr_mem[i] : init_byte(a);
    endfunction

    always @(posedge clk_in) begin
        if (rdy_in) begin
            if (bus.mem_wr) begin
                wr_mem[ram_idx(bus.mem_a)] <= bus.mem_dout;
                wr_vld[ram_idx(bus.mem_a)] <= 1'b1;
            end
            bus.mem_din <= ram_rd(bus.mem_a);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input int n);
        repeat (n) @(negedge clk_in);
        #1;
    endtask

    initial begin
        logic [31:0] wd;
        rst_in = 1'b1;
        rdy_in = 1'b1;
        bus.io_buffer_full   = 1'b0;
        bus.IC2MC_en         = 1'b0;
        bus.IC2MC_addr       = 32'h0;
        bus.LSB2MC_en        = 1'b0;
        bus.LSB2MC_wr        = 1'b0;
        bus.LSB2MC_addr      = 32'h0;
        bus.LSB2MC_len       = 2'b00;
        bus.LSB2MC_data      = 32'h0;
        bus.ROB2MC_pre_judge = 1'b1;

        // Reset state
        go(3);
        rst_in = 1'b0;
        chk("rst_mem_wr",   64'(bus.mem_wr),      64'h0);
        chk("rst_mem_a",    64'(bus.mem_a),       64'h0);
        chk("rst_mem_dout", 64'(bus.mem_dout),    64'h0);
        chk("rst_ic_en",    64'(bus.MC2IC_en),    64'h0);
        chk("rst_ls_en",    64'(bus.MC2LSB_en),   64'h0);
        chk("rst_ic_block", 64'(bus.MC2IC_block), 64'h0);
        chk("rst_ls_data",  64'(bus.MC2LSB_data), 64'h0);

        // Block fetch at 0x100: done in cycle E0+10
        go(1);
        bus.IC2MC_en   = 1'b1;
        bus.IC2MC_addr = 32'h100;
        for (int k = 0; k < 8; k++) begin
            go(1);
            chk("fetch_mem_a",  64'(bus.mem_a),  64'(32'h100 + 32'(k)));
            chk("fetch_mem_wr", 64'(bus.mem_wr), 64'h0);
        end
        go(1);
        chk("fetch_early_en", 64'(bus.MC2IC_en), 64'h0);
        go(1);
        chk("fetch_done_en", 64'(bus.MC2IC_en),    64'h1);
        chk("fetch_block",   64'(bus.MC2IC_block), 64'h1817161514131211);
        bus.IC2MC_en = 1'b0;
        go(1);
        chk("fetch_pulse_end", 64'(bus.MC2IC_en),    64'h0);
        chk("fetch_idle_a",    64'(bus.mem_a),       64'h0);
        chk("fetch_block_hold", 64'(bus.MC2IC_block), 64'h1817161514131211);

        // Collision: load wins, icache accepted after DONE
        go(1);
        bus.IC2MC_en    = 1'b1;
        bus.IC2MC_addr  = 32'h100;
        bus.LSB2MC_en   = 1'b1;
        bus.LSB2MC_wr   = 1'b0;
        bus.LSB2MC_addr = 32'h200;
        bus.LSB2MC_len  = 2'b10;
        go(1);
        chk("col_lsb_first", 64'(bus.mem_a), 64'h200);
        go(4);
        chk("col_ls_early", 64'(bus.MC2LSB_en), 64'h0);
        go(1);
        chk("col_ls_en",   64'(bus.MC2LSB_en),   64'h1);
        chk("col_ls_data", 64'(bus.MC2LSB_data), 64'hD4C3B2A1);
        chk("col_ic_quiet", 64'(bus.MC2IC_en),   64'h0);
        bus.LSB2MC_en = 1'b0;
        go(1);
        chk("col_done_no_accept", 64'(bus.mem_a), 64'h0);
        go(1);
        chk("col_ic_accept", 64'(bus.mem_a), 64'h100);
        go(9);
        chk("col_ic_en",    64'(bus.MC2IC_en),    64'h1);
        chk("col_ic_block", 64'(bus.MC2IC_block), 64'h1817161514131211);
        bus.IC2MC_en = 1'b0;

        // Store to UART region with io_buffer_full high for 3 cycles
        go(1);
        bus.LSB2MC_en      = 1'b1;
        bus.LSB2MC_wr      = 1'b1;
        bus.LSB2MC_addr    = 32'h30000;
        bus.LSB2MC_len     = 2'b00;
        bus.LSB2MC_data    = 32'h41;
        bus.io_buffer_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            go(1);
            chk("io_stall_wr", 64'(bus.mem_wr), 64'h0);
            chk("io_stall_a",  64'(bus.mem_a),  64'h30000);
        end
        go(1);
        bus.io_buffer_full = 1'b0;
        #1;
        chk("io_wr",   64'(bus.mem_wr),   64'h1);
        chk("io_dout", 64'(bus.mem_dout), 64'h41);
        go(1);
        chk("io_done", 64'(bus.MC2LSB_en), 64'h1);
        chk("io_wr_off", 64'(bus.mem_wr),  64'h0);
        bus.LSB2MC_en = 1'b0;
        go(1);
        chk("io_ram", 64'(ram_rd(32'h30000)), 64'h41);

        // Flush at E0+4 of a block fetch
        go(1);
        bus.IC2MC_en   = 1'b1;
        bus.IC2MC_addr = 32'h100;
        go(4);
        chk("flush_fetch_a", 64'(bus.mem_a), 64'h103);
        bus.ROB2MC_pre_judge = 1'b0;
        bus.IC2MC_en         = 1'b0;
        go(1);
        chk("flush_idle_a", 64'(bus.mem_a), 64'h0);
        bus.ROB2MC_pre_judge = 1'b1;
        for (int k = 0; k < 8; k++) begin
            go(1);
            chk("flush_no_done", 64'(bus.MC2IC_en), 64'h0);
        end

        // Flush during a 4-byte store: all bytes still written
        wd = 32'hCAFEBABE;
        go(1);
        bus.LSB2MC_en   = 1'b1;
        bus.LSB2MC_wr   = 1'b1;
        bus.LSB2MC_addr = 32'h400;
        bus.LSB2MC_len  = 2'b10;
        bus.LSB2MC_data = wd;
        for (int k = 0; k < 4; k++) begin
            go(1);
            if (k == 1) bus.ROB2MC_pre_judge = 1'b0;
            #1;
            chk("fst_wr",   64'(bus.mem_wr),   64'h1);
            chk("fst_a",    64'(bus.mem_a),    64'(32'h400 + 32'(k)));
            chk("fst_dout", 64'(bus.mem_dout), 64'(wd[8*k +: 8]));
        end
        go(1);
        chk("fst_done", 64'(bus.MC2LSB_en), 64'h1);
        bus.LSB2MC_en = 1'b0;
        go(1);
        bus.ROB2MC_pre_judge = 1'b1;
        chk("fst_ram3", 64'(ram_rd(32'h403)), 64'hCA);
        chk("fst_ram0", 64'(ram_rd(32'h400)), 64'hBE);

        // Load blocked by a flush in IDLE, then a 2-byte load paused 5 cycles
        go(1);
        bus.LSB2MC_en        = 1'b1;
        bus.LSB2MC_wr        = 1'b0;
        bus.LSB2MC_addr      = 32'h300;
        bus.LSB2MC_len       = 2'b01;
        bus.ROB2MC_pre_judge = 1'b0;
        go(1);
        chk("idle_flush_block", 64'(bus.mem_a), 64'h0);
        bus.ROB2MC_pre_judge = 1'b1;
        go(1);
        chk("pause_first_a", 64'(bus.mem_a), 64'h300);
        go(1);
        rdy_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) go(1);
            chk("pause_a",   64'(bus.mem_a),     64'h301);
            chk("pause_cnt", 64'(dut.cnt_q),     64'h1);
            chk("pause_en",  64'(bus.MC2LSB_en), 64'h0);
        end
        go(1);
        rdy_in = 1'b1;
        go(1);
        chk("pause_early", 64'(bus.MC2LSB_en), 64'h0);
        go(1);
        chk("pause_done", 64'(bus.MC2LSB_en),   64'h1);
        chk("pause_data", 64'(bus.MC2LSB_data), 64'h6B5A);
        bus.LSB2MC_en = 1'b0;

        // Illegal len 11 treated as 4 bytes, wrapping past 0xFFFFFFFF
        go(1);
        bus.LSB2MC_en   = 1'b1;
        bus.LSB2MC_addr = 32'hFFFF_FFFE;
        bus.LSB2MC_len  = 2'b11;
        go(2);
        chk("wrap_a1", 64'(bus.mem_a), 64'hFFFF_FFFF);
        go(1);
        chk("wrap_a2", 64'(bus.mem_a), 64'h0);
        go(1);
        chk("wrap_a3", 64'(bus.mem_a), 64'h1);
        go(2);
        chk("wrap_done", 64'(bus.MC2LSB_en),   64'h1);
        chk("wrap_data", 64'(bus.MC2LSB_data), 64'h04030201);
        bus.LSB2MC_en = 1'b0;

        // Store paused one cycle, then reset at byte k = 2
        go(1);
        bus.LSB2MC_en   = 1'b1;
        bus.LSB2MC_wr   = 1'b1;
        bus.LSB2MC_addr = 32'h500;
        bus.LSB2MC_len  = 2'b10;
        bus.LSB2MC_data = 32'h11223344;
        go(1);
        rdy_in = 1'b0;
        #1;
        chk("rdy_gate_wr", 64'(bus.mem_wr), 64'h0);
        go(1);
        rdy_in = 1'b1;
        #1;
        chk("rdy_resume_wr", 64'(bus.mem_wr), 64'h1);
        chk("rdy_resume_a",  64'(bus.mem_a),  64'h500);
        go(2);
        chk("rst_mid_a",  64'(bus.mem_a),  64'h502);
        chk("rst_mid_wr", 64'(bus.mem_wr), 64'h1);
        rst_in        = 1'b1;
        bus.LSB2MC_en = 1'b0;
        go(1);
        rst_in = 1'b0;
        chk("rst_abort_wr",    64'(bus.mem_wr),      64'h0);
        chk("rst_abort_a",     64'(bus.mem_a),       64'h0);
        chk("rst_abort_dout",  64'(bus.mem_dout),    64'h0);
        chk("rst_abort_data",  64'(bus.MC2LSB_data), 64'h0);
        chk("rst_abort_block", 64'(bus.MC2IC_block), 64'h0);
        for (int k = 0; k < 6; k++) begin
            chk("rst_no_done", 64'(bus.MC2LSB_en), 64'h0);
            go(1);
        end
        chk("rst_ram2", 64'(ram_rd(32'h502)), 64'h22);
        chk("rst_ram3", 64'(ram_rd(32'h503)), 64'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, sets the byte address width.
REQ-002 Parameter BLOCK_WIDTH, default 1, sets the log2 of words per icache block; BLOCK_SIZE = 1<<BLOCK_WIDTH and block bytes NB = 4*BLOCK_SIZE.
REQ-003 Ports SHALL be:
- clk_in  in  1  the single clock.
- rst_in  in  1  reset, synchronous and active-high.
- rdy_in  in  1  global pause; low SHALL freeze all internal state.
- mem_din  in  8  RAM read byte, valid one cycle after mem_a.
- mem_dout  out  8  RAM write byte.
- mem_a  out  ADDR_WIDTH  RAM byte address.
- mem_wr  out  1  1 = write, 0 = read.
- io_buffer_full  in  1  UART buffer full.
- IC2MC_en  in  1  icache request, level, held until done.
- IC2MC_addr  in  ADDR_WIDTH  block-aligned fetch address.
- MC2IC_en  out  1  block-done pulse.
- MC2IC_block  out  32*BLOCK_SIZE  block data, byte0 at bits [7:0].
- LSB2MC_en  in  1  LSB request, level, held until done.
- LSB2MC_wr  in  1  1 = store, 0 = load.
- LSB2MC_addr  in  ADDR_WIDTH  access address.
- LSB2MC_len  in  2  access length: 00 = 1, 01 = 2, 10 = 4 bytes; 11 is illegal.
- LSB2MC_data  in  32  store data, little-endian.
- MC2LSB_en  out  1  access-done pulse.
- MC2LSB_data  out  32  load data, zero-extended.
- ROB2MC_pre_judge  in  1  low = misprediction flush.

Function
REQ-004 FSM states SHALL be IDLE, IC_RD, LS_RD, LS_WR and DONE, with a byte counter cnt of width log2(NB)+1.
REQ-005 In IDLE, request selection SHALL follow fixed priority: a pending LSB2MC_en wins over IC2MC_en.
REQ-006 Selection edge E0: requester fields SHALL be latched into internal registers; later input changes SHALL be ignored until DONE.
REQ-007 IC_RD SHALL drive mem_a = addr+k, mem_wr = 0 in cycle E0+1+k, for k = 0..NB-1.
REQ-008 IC_RD SHALL capture mem_din into byte k of the block at the edge ending cycle E0+2+k.
REQ-009 LS_RD SHALL use the same timing as IC_RD with N = len bytes; unused upper bytes of MC2LSB_data SHALL be 0.
REQ-010 LS_WR SHALL drive mem_a = addr+k, mem_dout = data[8k+7:8k], mem_wr = 1 in cycle E0+1+k, for k = 0..N-1.
REQ-011 Read done pulse SHALL occur in cycle E0+N+2; write done pulse SHALL occur in cycle E0+N+1.
REQ-012 In DONE, the matching done output SHALL be high for exactly one cycle, with MC2IC_block or MC2LSB_data valid in that cycle and held until the next done.
REQ-013 No request SHALL be accepted in the DONE cycle; FSM SHALL return to IDLE the next cycle, and requesters SHALL drop en at the DONE edge.
REQ-014 When not writing, mem_wr SHALL be 0; mem_a SHALL be 0 in IDLE.
REQ-015 IO stall: in LS_WR, if addr[17:16] == 2'b11 and io_buffer_full == 1, the byte SHALL NOT be issued (mem_wr = 0) and cnt SHALL hold until io_buffer_full is 0.
REQ-016 rdy_in low SHALL hold state, cnt and outputs, except mem_wr, which SHALL be forced to 0; the RAM stalls with the core.
REQ-017 ROB2MC_pre_judge low SHALL take effect regardless of rdy_in:
- IC_RD or LS_RD: abort to IDLE next cycle with no done pulse.
- LS_WR: continue to completion, since committed stores are never dropped.
- IDLE: pending IC2MC_en or load SHALL NOT be accepted that cycle.
REQ-018 An abort in the DONE cycle SHALL NOT suppress an already-asserted pulse.
REQ-019 A 4-byte access crossing address 0xFFFFFFFF SHALL wrap modulo 2^ADDR_WIDTH.
REQ-020 For an illegal len value of 11, the access SHALL be treated as 4 bytes.

Reset
REQ-021 When rst_in is high at a clock edge, the next state SHALL be IDLE and cnt = 0.
REQ-022 After reset: mem_wr = 0, mem_a = 0, mem_dout = 0, MC2IC_en = 0, MC2LSB_en = 0, MC2IC_block = 0, MC2LSB_data = 0.
REQ-023 Reset SHALL take priority over rdy_in and ROB2MC_pre_judge and SHALL abort any access, including a store, mid-operation.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Block fetch: IC2MC_addr = 0x100, RAM bytes 0x11..0x18 -> MC2IC_en in cycle E0+10, MC2IC_block = 0x1817161514131211.
- Collision: IC2MC_en and LSB2MC_en rise in the same cycle with a load of len = 10 at 0x200 -> load served first, MC2LSB_en at E0+6, then icache accepted after DONE.
- Store with IO stall: store len = 00, data 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr = 0 for 3 cycles, then one write cycle with mem_dout = 0x41, then MC2LSB_en.
- Flush: ROB2MC_pre_judge low at E0+4 of a block fetch -> no MC2IC_en, IDLE next cycle; same flush during a 4-byte store -> all 4 writes complete and MC2LSB_en is asserted.
- Pause: rdy_in low for 5 cycles mid-load -> mem_wr = 0, cnt frozen, correct data and done delayed by exactly 5 cycles.
- Reset mid-store at k = 2 -> mem_wr = 0 next cycle, no done pulse, IDLE.
